// File: rtl/dcache_pkg.sv
// Shared types, geometry and address-field helpers for the write-back data cache.
package dcache_pkg;

    localparam int NUM_BLOCKS = 8;
    localparam int ADDR_W     = 30;
    localparam int IDX_W      = $clog2(NUM_BLOCKS);
    localparam int TAG_W      = ADDR_W - 2 - IDX_W;

    typedef enum logic [1:0] {
        S_COMPARE,
        S_WRITEBACK,
        S_ALLOCATE
    } state_e;

    function automatic logic [TAG_W-1:0] get_tag(input logic [ADDR_W-1:0] a);
        return a[ADDR_W-1 -: TAG_W];
    endfunction

    function automatic logic [IDX_W-1:0] get_idx(input logic [ADDR_W-1:0] a);
        return a[2 +: IDX_W];
    endfunction

    function automatic logic [1:0] get_off(input logic [ADDR_W-1:0] a);
        return a[1:0];
    endfunction

endpackage

// File: rtl/dcache_array.sv
// Line storage: valid/dirty bits with async clear, tags and 128-bit data.
// One combinational read port, one write port (word store or full-line refill).
module dcache_array
    import dcache_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic [IDX_W-1:0]   rd_idx,
    output logic               rd_valid,
    output logic               rd_dirty,
    output logic [TAG_W-1:0]   rd_tag,
    output logic [127:0]       rd_line,
    input  logic               we,
    input  logic               we_line,
    input  logic [IDX_W-1:0]   wr_idx,
    input  logic [1:0]         wr_off,
    input  logic [31:0]        wr_word,
    input  logic [127:0]       wr_line,
    input  logic [TAG_W-1:0]   wr_tag
);

    logic [NUM_BLOCKS-1:0] valid_q, valid_d;
    logic [NUM_BLOCKS-1:0] dirty_q, dirty_d;
    logic [TAG_W-1:0]      tag_q  [NUM_BLOCKS];
    logic [127:0]          data_q [NUM_BLOCKS];

    always_comb begin
        valid_d = valid_q;
        dirty_d = dirty_q;
        if (we) begin
            if (we_line) begin
                valid_d[wr_idx] = 1'b1;
                dirty_d[wr_idx] = 1'b0;
            end else begin
                dirty_d[wr_idx] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else begin
            valid_q <= valid_d;
            dirty_q <= dirty_d;
        end
    end

    // Tag and data need no reset: valid gates every use of them.
    always_ff @(posedge clk) begin
        if (we) begin
            if (we_line) begin
                tag_q[wr_idx]  <= wr_tag;
                data_q[wr_idx] <= wr_line;
            end else begin
                data_q[wr_idx][{wr_off, 5'b0} +: 32] <= wr_word;
            end
        end
    end

    assign rd_valid = valid_q[rd_idx];
    assign rd_dirty = dirty_q[rd_idx];
    assign rd_tag   = tag_q[rd_idx];
    assign rd_line  = data_q[rd_idx];

endmodule

// File: rtl/dcache_wb.sv
// Direct-mapped write-back, write-allocate data cache with a
// zero-latency hit path and a block-wide mem_ready handshake.
module dcache_wb
    import dcache_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                proc_read,
    input  logic                proc_write,
    input  logic [ADDR_W-1:0]   proc_addr,
    input  logic [31:0]         proc_wdata,
    output logic [31:0]         proc_rdata,
    output logic                proc_stall,
    output logic                mem_read,
    output logic                mem_write,
    output logic [ADDR_W-3:0]   mem_addr,
    output logic [127:0]        mem_wdata,
    input  logic [127:0]        mem_rdata,
    input  logic                mem_ready
);

    state_e              state_q, state_d;
    logic                mem_read_q, mem_read_d;
    logic                mem_write_q, mem_write_d;
    logic [ADDR_W-3:0]   mem_addr_q, mem_addr_d;
    logic [127:0]        mem_wdata_q, mem_wdata_d;

    logic                arr_valid, arr_dirty;
    logic [TAG_W-1:0]    arr_tag;
    logic [127:0]        arr_line;
    logic [IDX_W-1:0]    idx;
    logic [1:0]          off;
    logic                req, hit, cmp_hit, refill, we;

    assign idx     = get_idx(proc_addr);
    assign off     = get_off(proc_addr);
    assign req     = proc_read | proc_write;
    assign hit     = arr_valid && (arr_tag == get_tag(proc_addr));
    assign cmp_hit = (state_q == S_COMPARE) && req && hit;
    assign refill  = (state_q == S_ALLOCATE) && mem_ready;
    assign we      = refill || (cmp_hit && proc_write);

    dcache_array u_array (
        .clk      (clk),
        .rst_n    (rst_n),
        .rd_idx   (idx),
        .rd_valid (arr_valid),
        .rd_dirty (arr_dirty),
        .rd_tag   (arr_tag),
        .rd_line  (arr_line),
        .we       (we),
        .we_line  (refill),
        .wr_idx   (idx),
        .wr_off   (off),
        .wr_word  (proc_wdata),
        .wr_line  (mem_rdata),
        .wr_tag   (get_tag(proc_addr))
    );

    always_comb begin
        state_d     = state_q;
        mem_read_d  = mem_read_q;
        mem_write_d = mem_write_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        unique case (state_q)
            S_COMPARE: begin
                if (req && !hit) begin
                    if (arr_valid && arr_dirty) begin
                        state_d     = S_WRITEBACK;
                        mem_write_d = 1'b1;
                        mem_addr_d  = {arr_tag, idx};
                        mem_wdata_d = arr_line;
                    end else begin
                        state_d    = S_ALLOCATE;
                        mem_read_d = 1'b1;
                        mem_addr_d = proc_addr[ADDR_W-1:2];
                    end
                end
            end
            S_WRITEBACK: begin
                if (mem_ready) begin
                    state_d     = S_ALLOCATE;
                    mem_write_d = 1'b0;
                    mem_read_d  = 1'b1;
                    mem_addr_d  = proc_addr[ADDR_W-1:2];
                end
            end
            S_ALLOCATE: begin
                if (mem_ready) begin
                    state_d    = S_COMPARE;
                    mem_read_d = 1'b0;
                end
            end
            default: state_d = S_COMPARE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_COMPARE;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    // rst_n gates the stall so reset releases the core immediately.
    assign proc_stall = rst_n && ((state_q != S_COMPARE) || (req && !hit));
    assign proc_rdata = (cmp_hit && !proc_write) ? arr_line[{off, 5'b0} +: 32] : 32'h0;

    assign mem_read  = mem_read_q;
    assign mem_write = mem_write_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_dcache_wb.sv
// Directed self-checking bench for dcache_wb with a hand-driven
// block memory responder.
module tb_dcache_wb;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         proc_read, proc_write;
    logic [29:0]  proc_addr;
    logic [31:0]  proc_wdata, proc_rdata;
    logic         proc_stall;
    logic         mem_read, mem_write;
    logic [27:0]  mem_addr;
    logic [127:0] mem_wdata, mem_rdata;
    logic         mem_ready;

    int total = 0;
    int bad   = 0;

    localparam logic [127:0] BLK1 = {32'h4444_0003, 32'h3333_0002, 32'h2222_0001, 32'h1111_0000};
    localparam logic [127:0] BLK2 = {32'hE3E3_0013, 32'hE2E2_0012, 32'hE1E1_0011, 32'hE0E0_0010};
    localparam logic [127:0] BLK3 = {32'h7777_0023, 32'h6666_0022, 32'h5555_0021, 32'h9999_0020};
    localparam logic [127:0] BLK4 = {32'hABCD_0033, 32'hABCD_0032, 32'hABCD_0031, 32'hABCD_0030};

    dcache_wb dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .proc_read  (proc_read),
        .proc_write (proc_write),
        .proc_addr  (proc_addr),
        .proc_wdata (proc_wdata),
        .proc_rdata (proc_rdata),
        .proc_stall (proc_stall),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ready  (mem_ready)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst_n) begin
            total++;
            assert (!(mem_read && mem_write)) else begin
                bad++;
                $error("FAIL rw_overlap observed=%0b%0b expected=not both", mem_read, mem_write);
            end
        end
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_req(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (mem_read || mem_write) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    // Serve one memory request: lat cycles of request, ready in the last.
    task automatic mem_cycle(input bit is_wr, input logic [27:0] addr, input int lat,
                             input logic [127:0] rdata, input logic [127:0] exp_wdata);
        bit ok;
        wait_req(ok);
        chk("req_seen", 128'(ok), 128'(1));
        chk("mem_write", 128'(mem_write), 128'(is_wr));
        chk("mem_read", 128'(mem_read), 128'(!is_wr));
        chk("mem_addr", 128'(mem_addr), 128'(addr));
        if (is_wr) chk("mem_wdata", mem_wdata, exp_wdata);
        for (int i = 0; i < lat - 1; i++) begin
            tick();
            chk("hold_stall", 128'(proc_stall), 128'(1));
            chk("hold_addr", 128'(mem_addr), 128'(addr));
            chk("hold_req", 128'({mem_write, mem_read}), 128'({is_wr, !is_wr}));
            if (is_wr) chk("hold_wdata", mem_wdata, exp_wdata);
        end
        mem_rdata = rdata;
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        mem_rdata = '0;
    endtask

    initial begin
        rst_n      = 1'b0;
        proc_read  = 1'b0;
        proc_write = 1'b0;
        proc_addr  = '0;
        proc_wdata = '0;
        mem_rdata  = '0;
        mem_ready  = 1'b0;
        #1;
        chk("rst_stall", 128'(proc_stall), 128'(0));
        chk("rst_mem_read", 128'(mem_read), 128'(0));
        chk("rst_mem_write", 128'(mem_write), 128'(0));
        chk("rst_mem_addr", 128'(mem_addr), 128'(0));
        chk("rst_mem_wdata", mem_wdata, 128'(0));
        chk("rst_rdata", 128'(proc_rdata), 128'(0));
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // 1: cold load miss, then hits across the line
        proc_read = 1'b1;
        proc_addr = 30'h10;
        #1;
        chk("t1_miss_stall", 128'(proc_stall), 128'(1));
        tick();
        mem_cycle(1'b0, 28'h4, 4, BLK1, '0);
        chk("t1_stall_drop", 128'(proc_stall), 128'(0));
        chk("t1_rdata0", 128'(proc_rdata), 128'(32'h1111_0000));
        chk("t1_read_low", 128'(mem_read), 128'(0));
        proc_addr = 30'h11; #1;
        chk("t1_rdata1", 128'(proc_rdata), 128'(32'h2222_0001));
        proc_addr = 30'h12; #1;
        chk("t1_rdata2", 128'(proc_rdata), 128'(32'h3333_0002));
        proc_addr = 30'h13; #1;
        chk("t1_rdata3", 128'(proc_rdata), 128'(32'h4444_0003));
        chk("t1_hit_stall", 128'(proc_stall), 128'(0));
        tick();

        // 2: store hit, then read back
        proc_read  = 1'b0;
        proc_write = 1'b1;
        proc_addr  = 30'h11;
        proc_wdata = 32'hDEAD_BEEF;
        #1;
        chk("t2_st_stall", 128'(proc_stall), 128'(0));
        tick();
        chk("t2_no_mem", 128'({mem_read, mem_write}), 128'(0));
        proc_write = 1'b0;
        proc_read  = 1'b1;
        #1;
        chk("t2_rdata", 128'(proc_rdata), 128'(32'hDEAD_BEEF));
        tick();

        // 3: dirty eviction, same index, new tag
        proc_addr = 30'h30;
        #1;
        chk("t3_stall", 128'(proc_stall), 128'(1));
        mem_cycle(1'b1, 28'h4, 3, '0,
                  {32'h4444_0003, 32'h3333_0002, 32'hDEAD_BEEF, 32'h1111_0000});
        mem_cycle(1'b0, 28'hC, 3, BLK2, '0);
        chk("t3_stall_drop", 128'(proc_stall), 128'(0));
        chk("t3_rdata", 128'(proc_rdata), 128'(32'hE0E0_0010));
        tick();

        // 4: write miss to a clean line, then evict it
        proc_read  = 1'b0;
        proc_write = 1'b1;
        proc_addr  = 30'h08;
        proc_wdata = 32'h1234_5678;
        mem_cycle(1'b0, 28'h2, 2, BLK3, '0);
        chk("t4_merge_stall", 128'(proc_stall), 128'(0));
        tick();
        proc_write = 1'b0;
        proc_read  = 1'b1;
        proc_addr  = 30'h28;
        mem_cycle(1'b1, 28'h2, 2, '0, {BLK3[127:32], 32'h1234_5678});
        mem_cycle(1'b0, 28'hA, 2, BLK4, '0);
        chk("t4_rdata", 128'(proc_rdata), 128'(32'hABCD_0030));
        tick();

        // 5: reset during refill
        proc_addr = 30'h50;
        tick();
        chk("t5_mem_read", 128'(mem_read), 128'(1));
        chk("t5_mem_addr", 128'(mem_addr), 128'(28'h14));
        rst_n = 1'b0;
        #1;
        chk("t5_rst_read", 128'(mem_read), 128'(0));
        chk("t5_rst_stall", 128'(proc_stall), 128'(0));
        chk("t5_rst_addr", 128'(mem_addr), 128'(0));
        proc_read = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        proc_read = 1'b1;
        proc_addr = 30'h30;
        #1;
        chk("t5_remiss", 128'(proc_stall), 128'(1));
        mem_cycle(1'b0, 28'hC, 2, BLK2, '0);
        chk("t5_rdata", 128'(proc_rdata), 128'(32'hE0E0_0010));
        tick();

        // ready arriving while idle must be ignored
        proc_read = 1'b0;
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        chk("idle_ready", 128'({mem_read, mem_write, proc_stall}), 128'(0));

        // 6: long write-back hold
        proc_write = 1'b1;
        proc_addr  = 30'h31;
        proc_wdata = 32'hCAFE_F00D;
        tick();
        proc_write = 1'b0;
        proc_read  = 1'b1;
        proc_addr  = 30'h10;
        mem_cycle(1'b1, 28'hC, 20, '0, {BLK2[127:64], 32'hCAFE_F00D, BLK2[31:0]});
        mem_cycle(1'b0, 28'h4, 2, BLK1, '0);
        chk("t6_rdata", 128'(proc_rdata), 128'(32'h1111_0000));
        chk("t6_stall", 128'(proc_stall), 128'(0));
        tick();
        proc_read = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dcache_wb.md
Name: dcache_wb

Overview:
- Direct-mapped, write-back, write-allocate data cache between the RISC-V core's data port and the slow data memory (128-bit block bus, multi-cycle mem_ready handshake).
- Serves 32-bit word accesses from the core.
- Stalls the core on a miss while it writes back a dirty victim and refills the line.
- Lives inside CHIP. The core's store port (address, wdata, wen) is also tapped by the checker.

Parameters:
- NUM_BLOCKS, 8, number of cache lines; power of two; index width IDX_W = log2(NUM_BLOCKS).
- WORDS_PER_BLOCK, 4, fixed; 128-bit line, 2-bit word offset.
- ADDR_W, 30, processor word-address width.
- TAG_W, ADDR_W-2-IDX_W (25 at default), stored tag width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- proc_read  in  1  core load request.
- proc_write  in  1  core store request.
- proc_addr  in  30  word address (byte address [31:2]).
- proc_wdata  in  32  store data.
- proc_rdata  out  32  load data; valid when proc_stall=0 and proc_read=1.
- proc_stall  out  1  core must hold its request while high.
- mem_read  out  1  block read request to slow memory.
- mem_write  out  1  block write request to slow memory.
- mem_addr  out  28  block address (byte address [31:4]).
- mem_wdata  out  128  victim block, word0 in [31:0].
- mem_rdata  in  128  refill block, word0 in [31:0].
- mem_ready  in  1  one-cycle pulse; request done, mem_rdata valid for reads.

Behaviour:
- Address split:
  - offset = proc_addr[1:0]
  - index = proc_addr[2+:IDX_W]
  - tag = remaining upper bits
- Per line: valid, dirty, tag, 128-bit data.
- Reset (async assert, applies immediately):
  - state = COMPARE.
  - All valid and dirty bits = 0.
  - mem_read = 0, mem_write = 0, mem_addr = 0, mem_wdata = 0, proc_stall = 0, proc_rdata = 0.
  - Data array contents don't-care.
  - Reset mid-transaction abandons it; no write-back occurs.
- States:
  - COMPARE:
    - No request: idle, proc_stall = 0.
    - Hit (valid && tag match): zero-latency. proc_stall = 0 combinationally. Load data is muxed combinationally in the same cycle. A store updates the selected word and sets dirty at the clock edge.
    - Miss with victim dirty: proc_stall = 1, go to WRITEBACK.
    - Miss with victim clean: proc_stall = 1, go to ALLOCATE.
  - WRITEBACK:
    - mem_write = 1, mem_addr = {victim_tag, index}, mem_wdata = victim line. All three held stable until mem_ready.
    - On mem_ready: deassert mem_write, go to ALLOCATE.
  - ALLOCATE:
    - mem_read = 1, mem_addr = proc_addr[29:2], held stable until mem_ready.
    - On mem_ready: write mem_rdata into the line, set tag, valid = 1, dirty = 0, deassert mem_read, go to COMPARE.
    - The request then hits in COMPARE, one cycle after ready.
    - Pending stores merge on that hit cycle, setting dirty.
- proc_stall is high in WRITEBACK and ALLOCATE, and in COMPARE on a miss.
- mem_read and mem_write are never both high. Each deasserts in the cycle after mem_ready is sampled.
- mem_ready outside WRITEBACK/ALLOCATE is ignored.
- proc_read and proc_write both high: treated as a write.
- Core changing the request while stalled: unsupported; behaviour undefined.
- Data is stored byte-exact; no endian swizzling.
- Miss cost = write-back latency (if dirty) + refill latency + 1 cycle.

Decomposition:
- Package dcache_pkg holds:
  - state enum {S_COMPARE, S_WRITEBACK, S_ALLOCATE};
  - localparams IDX_W and TAG_W;
  - field-extract functions for tag, index and offset.
- One natural sub-module: dcache_array, covering valid/dirty/tag/data storage.
  - One read port, combinational.
  - One write port with two modes: word write (store hit) and full-line write (refill).
  - Async clear of valid and dirty.
- The FSM and handshake logic stay in dcache_wb.

Test Plan:
1. Cold load: reset, then read addr 0x0000010 (index 4). Expect mem_read = 1 with mem_addr = 0x0000004. Memory returns block {D3,D2,D1,D0} with mem_ready after 4 cycles. Expect stall to drop 1 cycle later and proc_rdata = D0 (offset 0). Reads of 0x11/0x12/0x13 then hit with zero stall, returning D1/D2/D3.
2. Store hit then clean read: write 0xDEADBEEF to 0x0000011 after case 1. Expect proc_stall = 0 and no mem activity; a later read returns 0xDEADBEEF.
3. Dirty eviction: access 0x0000030, which has the same index 4 and a different tag. Expect mem_write = 1 first, with mem_addr = 0x0000004 and mem_wdata[63:32] = 0xDEADBEEF. After ready, expect mem_read with mem_addr = 0x000000C; mem_read and mem_write are never overlapped.
4. Write miss to a clean line: write 0x12345678 to 0x0000008. Expect no write-back; refill at mem_addr = 0x0000002 with the word merged. An eviction of that line then writes back 0x12345678 in mem_wdata[31:0].
5. Reset mid-refill: assert rst_n = 0 while mem_read = 1. Expect mem_read = 0 and proc_stall = 0 immediately. After release, the prior address misses again (valid was cleared).
6. Ready hold: delay mem_ready by 20 cycles in WRITEBACK. Expect mem_addr and mem_wdata constant for all 20 cycles and proc_stall = 1 throughout.
